// File: rtl/decode_pipe_if.sv
// Fetch/writeback/execute-facing signal bundle for the decode stage.
// master = the side that supplies instructions and consumes decoded bundles,
// slave  = the decode stage itself.
interface decode_pipe_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
);
    localparam int ADDR_W = $clog2(NREG);

    // fetch side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [DATA_W-1:0] pc;
    // writeback port
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // branch resolution from execute
    logic              br_resolve;
    // execute side
    logic              out_valid;
    logic              out_ready;
    logic              reg_write_d;
    logic              mem_to_reg_d;
    logic              mem_write_d;
    logic              branch_d;
    logic              reg_dst_d;
    logic              illegal_d;
    logic [3:0]        alu_control_d;
    logic [1:0]        alu_src_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic [ADDR_W-1:0] rs_d;
    logic [ADDR_W-1:0] rt_d;
    logic [ADDR_W-1:0] rd_d;
    logic [4:0]        shamt_d;
    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] pc_plus_4_d;

    modport master (
        output in_valid, inst, pc, wb_en, wb_addr, wb_data, br_resolve, out_ready,
        input  in_ready, out_valid, reg_write_d, mem_to_reg_d, mem_write_d, branch_d,
               reg_dst_d, illegal_d, alu_control_d, alu_src_d, rd1_d, rd2_d,
               rs_d, rt_d, rd_d, shamt_d, imm_d, pc_plus_4_d
    );

    modport slave (
        input  in_valid, inst, pc, wb_en, wb_addr, wb_data, br_resolve, out_ready,
        output in_ready, out_valid, reg_write_d, mem_to_reg_d, mem_write_d, branch_d,
               reg_dst_d, illegal_d, alu_control_d, alu_src_d, rd1_d, rd2_d,
               rs_d, rt_d, rd_d, shamt_d, imm_d, pc_plus_4_d
    );
endinterface

// File: rtl/decode_pipe.sv
// MIPS32 decode stage: one registered bundle, regfile with writeback bypass,
// load-use bubble and a branch hold until execute resolves the branch.
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_pipe_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {RUN, BR_WAIT} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       reg_dst;
        logic       illegal;
        logic [3:0] alu_control;
        logic [1:0] alu_src;
    } ctl_t;

    typedef struct packed {
        ctl_t              ctl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_plus_4;
    } bundle_t;

    state_t            state_q, state_d;
    bundle_t           out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    ctl_t              ctl;
    logic [5:0]        op, funct;
    logic [ADDR_W-1:0] rs_i, rt_i, rd_i;
    logic [DATA_W-1:0] rd1_i, rd2_i;
    logic              reads_rt, hazard, in_ready, accept;

    assign op    = bus.inst[31:26];
    assign funct = bus.inst[5:0];
    assign rs_i  = bus.inst[21 +: ADDR_W];
    assign rt_i  = bus.inst[16 +: ADDR_W];
    assign rd_i  = bus.inst[11 +: ADDR_W];

    // Control decode; the all-zero word is a NOP, not an SLL
    always_comb begin
        ctl = '0;
        if (bus.inst != 32'h0) begin
            case (op)
                OP_RTYPE: begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 1'b1;
                    case (funct)
                        6'h20, 6'h21: ctl.alu_control = 4'b0000;
                        6'h23:        ctl.alu_control = 4'b0001;
                        6'h24:        ctl.alu_control = 4'b0010;
                        6'h25:        ctl.alu_control = 4'b0011;
                        6'h27:        ctl.alu_control = 4'b0100;
                        6'h26:        ctl.alu_control = 4'b0101;
                        6'h2A:        ctl.alu_control = 4'b1001;
                        6'h2B:        ctl.alu_control = 4'b1010;
                        6'h00: begin ctl.alu_control = 4'b0110; ctl.alu_src = 2'b01; end
                        6'h03: begin ctl.alu_control = 4'b0111; ctl.alu_src = 2'b01; end
                        6'h02: begin ctl.alu_control = 4'b1000; ctl.alu_src = 2'b01; end
                        default: begin ctl = '0; ctl.illegal = 1'b1; end
                    endcase
                end
                OP_ADDIU: begin ctl.reg_write = 1'b1; ctl.alu_src = 2'b10; end
                OP_LW: begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 1'b1;
                    ctl.alu_src    = 2'b10;
                end
                OP_SW:  begin ctl.mem_write = 1'b1; ctl.alu_src = 2'b10; end
                OP_BEQ: begin ctl.branch = 1'b1; ctl.alu_control = 4'b0001; end
                default: ctl.illegal = 1'b1;
            endcase
        end
    end

    // Operand read with same-cycle writeback bypass; r0 always reads zero
    always_comb begin
        rd1_i = rf_q[rs_i];
        rd2_i = rf_q[rt_i];
        if (bus.wb_en && bus.wb_addr == rs_i) rd1_i = bus.wb_data;
        if (bus.wb_en && bus.wb_addr == rt_i) rd2_i = bus.wb_data;
        if (rs_i == '0) rd1_i = '0;
        if (rt_i == '0) rd2_i = '0;
    end

    // Load-use: the load sitting in the output register feeds this instruction
    assign reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    assign hazard   = out_valid_q && out_q.ctl.mem_to_reg && (out_q.rt != '0) &&
                      ((out_q.rt == rs_i) || (reads_rt && out_q.rt == rt_i));
    assign in_ready = (state_q == RUN) && !hazard && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Output register: load on accept, drain on out_ready, else hold
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            out_d.ctl       = ctl;
            out_d.rd1       = rd1_i;
            out_d.rd2       = rd2_i;
            out_d.rs        = rs_i;
            out_d.rt        = rt_i;
            out_d.rd        = rd_i;
            out_d.shamt     = bus.inst[10:6];
            out_d.imm       = {{(DATA_W-16){bus.inst[15]}}, bus.inst[15:0]};
            out_d.pc_plus_4 = bus.pc + DATA_W'(4);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Branch hold: stall fetch from BEQ accept until execute resolves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && op == OP_BEQ) state_d = BR_WAIT;
            BR_WAIT: if (bus.br_resolve)         state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Regfile next value; writes to r0 are dropped
    always_comb begin
        rf_d = rf_q;
        if (bus.wb_en && bus.wb_addr != '0) rf_d[bus.wb_addr] = bus.wb_data;
    end

    // State, output bundle and regfile registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rf_q        <= rf_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.reg_write_d   = out_q.ctl.reg_write;
    assign bus.mem_to_reg_d  = out_q.ctl.mem_to_reg;
    assign bus.mem_write_d   = out_q.ctl.mem_write;
    assign bus.branch_d      = out_q.ctl.branch;
    assign bus.reg_dst_d     = out_q.ctl.reg_dst;
    assign bus.illegal_d     = out_q.ctl.illegal;
    assign bus.alu_control_d = out_q.ctl.alu_control;
    assign bus.alu_src_d     = out_q.ctl.alu_src;
    assign bus.rd1_d         = out_q.rd1;
    assign bus.rd2_d         = out_q.rd2;
    assign bus.rs_d          = out_q.rs;
    assign bus.rt_d          = out_q.rt;
    assign bus.rd_d          = out_q.rd;
    assign bus.shamt_d       = out_q.shamt;
    assign bus.imm_d         = out_q.imm;
    assign bus.pc_plus_4_d   = out_q.pc_plus_4;
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised instruction-decode stage for the MIPS32 pipeline. It sits between fetch and execute. It registers one instruction per accepted handshake, decodes it into execute-stage control, and reads operands from an internal register file with writeback bypass. It also enforces two interlocks: a load-use bubble, and a branch hold that lasts until execute resolves the branch.

## Interface
- DATA_W, 32, datapath and register width
- NREG, 32, architectural register count (power of two; ADDR_W = log2(NREG), max 32)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  fetch offers inst/pc
- in_ready  output  1  stage accepts this cycle
- inst  input  32  instruction word
- pc  input  DATA_W  instruction address
- wb_en / wb_addr / wb_data  input  1 / ADDR_W / DATA_W  register writeback port
- br_resolve  input  1  one-cycle pulse from execute: branch outcome known
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- reg_write_d, mem_to_reg_d, mem_write_d, branch_d, reg_dst_d, illegal_d  output  1 each  control bits
- alu_control_d  output  4  ALU op
- alu_src_d  output  2  00 reg, 01 shamt, 10 imm
- rd1_d, rd2_d  output  DATA_W  operands
- rs_d, rt_d, rd_d  output  ADDR_W  register indices (inst fields truncated to ADDR_W)
- shamt_d  output  5  shift amount
- imm_d  output  DATA_W  sign-extended inst[15:0]
- pc_plus_4_d  output  DATA_W  pc + 4, modulo 2^DATA_W

## Operation
- **Decode table** (op/funct hex → alu_control, alu_src, reg_dst, other controls):
  - R-type (op 00):
    - ADD 20 / ADDU 21 → 0000
    - SUBU 23 → 0001
    - AND 24 → 0010
    - OR 25 → 0011
    - NOR 27 → 0100
    - XOR 26 → 0101
    - SLT 2A → 1001
    - SLTU 2B → 1010
    - all of the above: src 00, reg_dst 1, reg_write 1
    - SLL 00 → 0110, SRA 03 → 0111, SRL 02 → 1000; src 01, reg_dst 1, reg_write 1
    - SLL with inst == 0 is a NOP: all controls 0
  - I-type:
    - ADDIU 09 → 0000, src 10, reg_dst 0, reg_write 1
    - LW 23 → 0000, src 10, reg_write 1, mem_to_reg 1
    - SW 2B → 0000, src 10, mem_write 1
    - BEQ 04 → 0001, src 00, branch 1
  - Anything else, including JR: illegal_d = 1, all other controls 0. The bundle still flows.
- **Register file**
  - NREG × DATA_W; register 0 reads 0 and ignores writes.
  - Read is combinational on inst rs/rt and captured at accept.
  - Bypass: if wb_en and wb_addr matches the read index (nonzero) in the accept cycle, capture wb_data.
- **Handshake**
  - Accept when in_valid && in_ready.
  - Output register loads on accept.
  - Output register clears out_valid when out_ready && !accept.
  - Output register holds when out_valid && !out_ready.
- **Load-use hazard**
  - Raised when all of the following hold:
    - out_valid and mem_to_reg_d
    - rt_d ≠ 0
    - rt_d equals inst rs, or rt_d equals inst rt and the instruction reads rt (R-type, BEQ, SW)
  - While raised, in_ready = 0.
- **FSM**
  - States: RUN and BR_WAIT.
  - RUN → BR_WAIT on accept of BEQ.
  - BR_WAIT → RUN on br_resolve.
  - br_resolve in RUN is ignored.
- **in_ready** = (state == RUN) && !hazard && (!out_valid || out_ready).

## Timing
- **Reset**
  - Register file all zero.
  - FSM in RUN.
  - out_valid 0; all control outputs, indices, operands, imm and pc_plus_4_d 0.
- **Reset mid-operation:** asserting rst in BR_WAIT or with a stalled bundle discards both immediately.
- **Latency:** accept at edge N → bundle on outputs after edge N, out_valid = 1.
- **Throughput:** one instruction per cycle when there is no hazard, no branch, and out_ready stays high.
- **Load-use bubble:** exactly one cycle when out_ready = 1. The load drains, out_valid drops to 0, the hazard clears, and the dependent instruction is accepted the next cycle.
- **Branch hold:** in_ready stays 0 from the cycle after BEQ accept through the cycle br_resolve is high. First possible new accept is the cycle after br_resolve.
- **Writeback:**
  - A register write commits at the edge. The bypass covers a read in the same cycle.
  - A write and a read of register 0 in the same cycle reads 0.
- **Simultaneous accept and out_ready:** the new bundle replaces the old one; no bubble.

## Test plan
- **ADDU:** reset; write r1 = 5 and r2 = 7 via wb; offer ADDU r3,r1,r2 (0x00221821) with out_ready = 1 → one cycle later out_valid = 1, rd1_d = 5, rd2_d = 7, alu_control 0000, reg_dst 1, rd_d = 3.
- **Writeback bypass:** wb writes r4 = 0xDEAD in the same cycle ADDIU r5,r4,-1 (0x2485FFFF) is accepted → rd1_d = 0xDEAD, imm_d = 0xFFFFFFFF, alu_src 10.
- **Load-use:** LW r6,0(r0) followed by ADDU r7,r6,r0 → in_ready = 0 for one cycle, a one-cycle out_valid = 0 gap, then the ADDU issues. SW r6 following LW r6 also stalls.
- **Branch hold:** accept BEQ r1,r2,+4 → in_ready stays 0 for 3 cycles; pulse br_resolve → in_ready = 1 on the following cycle. br_resolve pulsed in RUN has no effect.
- **Backpressure:** hold out_ready = 0 for 4 cycles with in_valid = 1 → the bundle is stable, in_ready = 0, no instruction is lost or duplicated after release.
- **Illegal and reset:**
  - Op 0x3F → illegal_d = 1 with all other controls 0.
  - Asserting rst while in BR_WAIT → out_valid = 0 and in_ready = 1 once rst deasserts.
